// File: rtl/inst_mem_loadable.sv
// -----------------------------------------------------------------------------
// inst_mem_loadable
//   Writable instruction memory placed between the fetch stage and the decoder.
//   Holds DEPTH = 2**ADDR_W words of DATA_W bits. Fetches are served with a
//   one-cycle registered read. After reset the array is zeroed by a CLEAR sweep
//   (DEPTH cycles). A boot loader can then stream a program in from address 0
//   over a valid/ready handshake.
//
//   Optional feature macro: INST_MEM_PARITY_EN
//     When it is defined, each word stores an extra even-parity bit. The
//     parity_err port flags a mismatch on the fetch response.
//
// Ports
//   clk, rst_n   rising-edge clock, async active-low reset
//   a            fetch word address
//   req_valid    fetch request
//   req_ready    fetch accepted when req_valid & req_ready (IDLE only)
//   inst         registered fetched instruction
//   inst_valid   inst carries the fetch accepted in the previous cycle
//   load_start   one-cycle pulse that starts a program load at address 0
//   load_data    word to store
//   load_valid   load_data present
//   load_last    marks the final word of the load
//   load_ready   loader word accepted (LOAD only)
//   load_done    one-cycle pulse after the final word is written
//   busy         high in CLEAR or LOAD
//   parity_err   stored parity mismatch on the fetch response (macro only)
// -----------------------------------------------------------------------------
module inst_mem_loadable #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] a,
  input  logic              req_valid,
  output logic              req_ready,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  input  logic              load_start,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_valid,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              busy
`ifdef INST_MEM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

`ifdef INST_MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_LOAD
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] w_wr_ptr_nxt;
  logic              w_mem_we;
  logic [DATA_W-1:0] w_mem_wdata;
  logic [MEM_W-1:0]  w_mem_word;
  logic              w_done_nxt;
  logic              w_fetch;
  logic [MEM_W-1:0]  w_rd_word;
  logic              r_load_done;
  logic [DATA_W-1:0] r_inst;
  logic              r_inst_valid;

  logic [MEM_W-1:0]  r_mem [DEPTH];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: Sequential state uses non-blocking assignments only. All blocks then
  // sample pre-edge values, regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_CLEAR;
      r_wr_ptr    <= '0;
      r_load_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_load_done <= w_done_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and write-port decode
  // ---------------------------------------------------------------------------
  // NOTE: Every output of this block gets a default first. A path that forgets
  // an assignment then keeps the default and cannot infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_ptr_nxt = r_wr_ptr;
    w_mem_we     = 1'b0;
    w_mem_wdata  = '0;
    w_done_nxt   = 1'b0;

    unique case (r_state)
      S_CLEAR: begin
        w_mem_we = 1'b1;
        if (r_wr_ptr == PTR_LAST) begin
          w_wr_ptr_nxt = '0;
          w_state_nxt  = S_IDLE;
        end else begin
          w_wr_ptr_nxt = r_wr_ptr + 1'b1;
        end
      end

      S_IDLE: begin
        if (load_start) begin
          w_wr_ptr_nxt = '0;
          w_state_nxt  = S_LOAD;
        end
      end

      S_LOAD: begin
        if (load_valid) begin
          w_mem_we    = 1'b1;
          w_mem_wdata = load_data;
          // The pointer never wraps. A full array ends the load even without load_last.
          if (load_last || (r_wr_ptr == PTR_LAST)) begin
            w_wr_ptr_nxt = '0;
            w_state_nxt  = S_IDLE;
            w_done_nxt   = 1'b1;
          end else begin
            w_wr_ptr_nxt = r_wr_ptr + 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt  = S_CLEAR;
        w_wr_ptr_nxt = '0;
      end
    endcase
  end

`ifdef INST_MEM_PARITY_EN
  assign w_mem_word = {^w_mem_wdata, w_mem_wdata};
`else
  assign w_mem_word = w_mem_wdata;
`endif

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  // NOTE: The array has no reset branch. The CLEAR sweep defines its contents.
  // Without a reset term the array can map onto RAM macros instead of flops.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_wr_ptr] <= w_mem_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch port: reads happen only in IDLE and writes only in CLEAR or LOAD,
  // so a same-address read/write collision cannot occur.
  // ---------------------------------------------------------------------------
  assign w_fetch   = req_valid && (r_state == S_IDLE);
  assign w_rd_word = r_mem[a];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst       <= '0;
      r_inst_valid <= 1'b0;
    end else begin
      r_inst_valid <= w_fetch;
      if (w_fetch) begin
        r_inst <= w_rd_word[DATA_W-1:0];
      end
    end
  end

`ifdef INST_MEM_PARITY_EN
  logic r_parity_err;

  // Even parity over {parity, data} is zero for an intact word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_fetch && (^w_rd_word);
    end
  end

  assign parity_err = r_parity_err;
`endif

  assign req_ready  = (r_state == S_IDLE);
  assign load_ready = (r_state == S_LOAD);
  assign busy       = (r_state != S_IDLE);
  assign load_done  = r_load_done;
  assign inst       = r_inst;
  assign inst_valid = r_inst_valid;

endmodule

// File: tb/tb_inst_mem_loadable.sv
// -----------------------------------------------------------------------------
// tb_inst_mem_loadable
//   Scoreboard bench for inst_mem_loadable with ADDR_W=6 and DATA_W=32.
//   The stimulus tasks push the expected fetch responses into a queue. A monitor
//   process pops one entry each time inst_valid is seen and compares it with
//   the DUT output. Inputs are driven on the falling edge and outputs are
//   sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_inst_mem_loadable;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              perr;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] a;
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] inst;
  logic              inst_valid;
  logic              load_start;
  logic [DATA_W-1:0] load_data;
  logic              load_valid;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
  logic              busy;
`ifdef INST_MEM_PARITY_EN
  logic              parity_err;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_done  = 0;
  exp_t sb_q[$];
  logic [DATA_W-1:0] words[$];

  inst_mem_loadable #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .inst       (inst),
    .inst_valid (inst_valid),
    .load_start (load_start),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_last  (load_last),
    .load_ready (load_ready),
    .load_done  (load_done),
    .busy       (busy)
`ifdef INST_MEM_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: each response is compared against the oldest expectation.
  always @(negedge clk) begin
    if (load_done) n_done++;
    if (inst_valid) begin
      if (sb_q.size() == 0) begin
        check(1'b0, "unexpected_inst_valid", {32'd0, inst}, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check(inst == e.data, "fetch_data", {32'd0, inst}, {32'd0, e.data});
`ifdef INST_MEM_PARITY_EN
        check(parity_err == e.perr, "parity_err", {63'd0, parity_err}, {63'd0, e.perr});
`endif
      end
    end
  end

  task automatic fetch(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp_data,
                       input logic exp_perr);
    int k;
    exp_t e;
    @(negedge clk);
    a = addr;
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      check(1'b0, "fetch_ready_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
    end else begin
      e.data = exp_data;
      e.perr = exp_perr;
      sb_q.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
      check(inst_valid == 1'b1, "fetch_latency", {63'd0, inst_valid}, 64'd1);
    end
  endtask

  // Streams the words queue. It returns how many words the DUT accepted.
  task automatic do_load(input int n, input bit use_last, input int gap, output int acc);
    acc = 0;
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = words[i];
      load_last  = use_last && (i == n - 1);
      if (load_ready) acc++;
      @(negedge clk);
      load_valid = 1'b0;
      load_last  = 1'b0;
      for (int g = 0; g < gap; g++) @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic wait_clear(output int cnt);
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    if (busy) check(1'b0, "clear_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int acc;
    rst_n = 1'b0;
    a = '0;
    req_valid = 1'b0;
    load_start = 1'b0;
    load_data = '0;
    load_valid = 1'b0;
    load_last = 1'b0;
    #22;
    // Reset state
    check(req_ready == 1'b0, "rst_req_ready", {63'd0, req_ready}, 64'd0);
    check(inst_valid == 1'b0, "rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    check(inst == '0, "rst_inst", {32'd0, inst}, 64'd0);
    check(load_ready == 1'b0, "rst_load_ready", {63'd0, load_ready}, 64'd0);
    check(load_done == 1'b0, "rst_load_done", {63'd0, load_done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // CLEAR lasts DEPTH = 64 cycles.
    wait_clear(cnt);
    check(cnt == 64, "clear_cycles", 64'(cnt), 64'd64);
    check(req_ready == 1'b1, "idle_req_ready", {63'd0, req_ready}, 64'd1);
    fetch(6'h3F, 32'h0000_0000, 1'b0);

    // Three-word load with load_last on the third word.
    words = '{32'h0022_1820, 32'h0425_2005, 32'h3C24_0001};
    do_load(3, 1'b1, 0, acc);
    check(acc == 3, "load3_accepted", 64'(acc), 64'd3);
    check(n_done == 1, "load3_done_count", 64'(n_done), 64'd1);
    check(load_ready == 1'b0, "load3_ready_low", {63'd0, load_ready}, 64'd0);
    fetch(6'd0, 32'h0022_1820, 1'b0);
    fetch(6'd1, 32'h0425_2005, 1'b0);
    fetch(6'd2, 32'h3C24_0001, 1'b0);
    fetch(6'd3, 32'h0000_0000, 1'b0);

    // The same words with two-cycle gaps between valid beats.
    do_load(3, 1'b1, 2, acc);
    check(acc == 3, "gap_accepted", 64'(acc), 64'd3);
    check(n_done == 2, "gap_done_count", 64'(n_done), 64'd2);
    fetch(6'd2, 32'h3C24_0001, 1'b0);
    fetch(6'd1, 32'h0425_2005, 1'b0);
    fetch(6'd3, 32'h0000_0000, 1'b0);

    // Overrun: 70 words with no load_last. Only 64 words are taken.
    words.delete();
    for (int k = 1; k <= 70; k++) words.push_back(32'h0000_1000 + 32'(k));
    do_load(70, 1'b0, 0, acc);
    check(acc == 64, "overrun_accepted", 64'(acc), 64'd64);
    check(load_ready == 1'b0, "overrun_ready_low", {63'd0, load_ready}, 64'd0);
    check(n_done == 3, "overrun_done_count", 64'(n_done), 64'd3);
    fetch(6'd0, 32'h0000_1001, 1'b0);
    fetch(6'd63, 32'h0000_1040, 1'b0);

    // Same-cycle fetch and load_start: the fetch returns the old contents.
    @(negedge clk);
    a = 6'd1;
    req_valid = 1'b1;
    load_start = 1'b1;
    check(req_ready == 1'b1, "same_cycle_ready", {63'd0, req_ready}, 64'd1);
    begin
      exp_t e;
      e.data = 32'h0000_1002;
      e.perr = 1'b0;
      sb_q.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
    load_start = 1'b0;
    check(load_ready == 1'b1, "same_cycle_enter_load", {63'd0, load_ready}, 64'd1);
    load_valid = 1'b1;
    load_data = 32'hAAAA_0000;
    @(negedge clk);
    load_valid = 1'b0;
    // A reset pulse in the middle of LOAD aborts it and restarts CLEAR.
    rst_n = 1'b0;
    #1;
    check(inst == '0, "midload_rst_inst", {32'd0, inst}, 64'd0);
    check(busy == 1'b1, "midload_rst_busy", {63'd0, busy}, 64'd1);
    check(load_ready == 1'b0, "midload_rst_load_ready", {63'd0, load_ready}, 64'd0);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    wait_clear(cnt);
    check(n_done == 3, "midload_no_done", 64'(n_done), 64'd3);
    fetch(6'd1, 32'h0000_0000, 1'b0);
    fetch(6'd0, 32'h0000_0000, 1'b0);

`ifdef INST_MEM_PARITY_EN
    // Corrupt one stored data bit at address 5 and leave its parity bit unchanged.
    @(negedge clk);
    dut.r_mem[5] = dut.r_mem[5] ^ 33'd1;
    fetch(6'd5, 32'h0000_0001, 1'b1);
    fetch(6'd4, 32'h0000_0000, 1'b0);
    fetch(6'd6, 32'h0000_0000, 1'b0);
`endif

    repeat (3) @(negedge clk);
    check(sb_q.size() == 0, "scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
